feistel_encrypt_ctrl: RTL and testbench
=======================================

FEISTEL_ENCRYPT_CTRL -- requirements
Module: feistel_encrypt_ctrl

Interface
REQ-001 Parameters SHALL be:
- SBOX_WIDTH, 8: S-box entry width.
- DATA_WIDTH, 256: block width.
- MAX_INFLIGHT, 4: maximum blocks held in engine plus output buffer.
- WDOG_CYCLES, 255: watchdog limit.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin configuration.
- s_sbox_data, in, SBOX_WIDTH: upstream S-box byte.
- s_sbox_valid, in, 1 / s_sbox_ready, out, 1: S-box byte handshake.
- eng_sbox_out, out, SBOX_WIDTH / eng_sbox_valid, out, 1: S-box stream to engine.
- eng_key_valid, out, 1: key-load strobe to engine.
- s_pt_data, in, DATA_WIDTH: upstream plaintext block.
- s_pt_valid, in, 1 / s_pt_ready, out, 1: plaintext handshake.
- eng_plaintext, out, DATA_WIDTH / eng_tvalid, out, 1: block issue to engine.
- eng_ciphertext, in, DATA_WIDTH / eng_valid, in, 1: engine result, no backpressure.
- m_ct_data, out, DATA_WIDTH: ciphertext to downstream.
- m_ct_valid, out, 1 / m_ct_ready, in, 1: ciphertext handshake.
- cfg_done, out, 1: engine configured.
- busy, out, 1: blocks outstanding.
- err, out, 1: sticky watchdog error.

Function
REQ-003 FSM states SHALL be IDLE, SBOX, KEY, RUN.
REQ-004 IDLE SHALL go to SBOX on start=1 and clear the 8-bit byte counter.
REQ-005 In SBOX, s_sbox_ready SHALL be 1; each accepted byte SHALL appear on eng_sbox_out with eng_sbox_valid=1 exactly one cycle later.
REQ-006 Bytes SHALL be forwarded in arrival order; eng_sbox_valid SHALL be 0 in cycles after no acceptance.
REQ-007 Acceptance of the 256th byte SHALL move the FSM to KEY; s_sbox_ready SHALL be 0 outside SBOX.
REQ-008 KEY SHALL hold eng_key_valid=1 for exactly 2 cycles, beginning the cycle after the last eng_sbox_valid, then enter RUN.
REQ-009 cfg_done SHALL be 1 only in RUN.
REQ-010 Credit count SHALL equal eng_cnt (blocks issued, not yet returned) plus fifo_cnt (output buffer occupancy).
REQ-011 s_pt_ready SHALL be 1 iff state is RUN and credit count < MAX_INFLIGHT.
REQ-012 An accepted block SHALL be registered onto eng_plaintext with eng_tvalid=1 for exactly one cycle, the cycle after acceptance; eng_plaintext SHALL hold its value otherwise.
REQ-013 eng_valid SHALL push eng_ciphertext into a MAX_INFLIGHT-deep FIFO; credit gating SHALL make overflow impossible.
REQ-014 m_ct_valid SHALL be 1 iff fifo_cnt > 0; a pop occurs on m_ct_valid & m_ct_ready; blocks SHALL leave in issue order.
REQ-015 Simultaneous events SHALL resolve per counter:
- Issue and eng_valid in the same cycle: eng_cnt unchanged.
- Push and pop in the same cycle: fifo_cnt unchanged.
- Push and pop with an empty FIFO: data SHALL NOT bypass; m_ct_valid rises the following cycle.
REQ-016 eng_valid with eng_cnt=0 SHALL be ignored; eng_cnt SHALL NOT underflow.
REQ-017 Reconfiguration: start in RUN with credit count 0 SHALL go to SBOX; otherwise start SHALL be ignored, as SHALL start in SBOX or KEY.
REQ-018 busy SHALL equal (credit count != 0).

Reset
REQ-019 On reset_n=0, asynchronously and independent of clk, the FSM SHALL enter IDLE and all counters and FIFO pointers SHALL clear.
REQ-020 While reset_n=0, these outputs SHALL be 0: s_sbox_ready, eng_sbox_valid, eng_key_valid, eng_tvalid, s_pt_ready, m_ct_valid, cfg_done, busy, err. eng_sbox_out, eng_plaintext and m_ct_data SHALL also be 0.
REQ-021 Reset mid-SBOX or mid-RUN SHALL discard all partial state; a full start sequence SHALL be required afterwards.

Configuration
REQ-022 Macro FEISTEL_CTRL_WDOG_EN SHALL control the watchdog.
REQ-023 When FEISTEL_CTRL_WDOG_EN is defined:
- A counter SHALL increment each cycle with eng_cnt > 0 and eng_valid=0.
- It SHALL clear on eng_valid or when eng_cnt=0.
- On reaching WDOG_CYCLES it SHALL set err, which stays set until reset.
- Once err is set, s_pt_ready SHALL be 0.
REQ-024 When FEISTEL_CTRL_WDOG_EN is undefined, err SHALL be tied to 0 and no watchdog logic SHALL exist.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Config: reset, start, 256 bytes 0xFF..0x00 with continuous valid -> eng_sbox_out 0xFF..0x00 on consecutive cycles, then eng_key_valid high 2 cycles, then cfg_done=1.
- Config gaps: s_sbox_valid toggling every other cycle -> same 256-byte order, eng_sbox_valid gaps matching the input gaps.
- Credit limit: m_ct_ready=0, engine model with latency 30, 6 blocks offered -> exactly 4 accepted, s_pt_ready=0 until the first pop.
- Order: blocks 0x1122..EEFF and 0xFFEE..6677 back-to-back, m_ct_ready=1 -> same order out; busy returns to 0.
- Reset: reset_n pulsed low mid-RUN with 2 blocks inflight -> all outputs 0 immediately; IDLE; start required again.
- Watchdog (macro defined): WDOG_CYCLES=16, engine never returns eng_valid -> err=1 after 16 cycles and s_pt_ready=0; macro undefined -> err stays 0.

Source files
------------

// File: rtl/feistel_encrypt_ctrl.sv
// Control front-end for a Feistel block-cipher engine: S-box/key configuration, credit-gated issue, ordered output buffer.
// Optional watchdog on a stalled engine, enabled by defining FEISTEL_CTRL_WDOG_EN.
module feistel_encrypt_ctrl #(
   parameter int unsigned SBOX_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 256,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned WDOG_CYCLES  = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [SBOX_WIDTH-1:0] s_sbox_data,
   input  logic                  s_sbox_valid,
   output logic                  s_sbox_ready,
   output logic [SBOX_WIDTH-1:0] eng_sbox_out,
   output logic                  eng_sbox_valid,
   output logic                  eng_key_valid,
   input  logic [DATA_WIDTH-1:0] s_pt_data,
   input  logic                  s_pt_valid,
   output logic                  s_pt_ready,
   output logic [DATA_WIDTH-1:0] eng_plaintext,
   output logic                  eng_tvalid,
   input  logic [DATA_WIDTH-1:0] eng_ciphertext,
   input  logic                  eng_valid,
   output logic [DATA_WIDTH-1:0] m_ct_data,
   output logic                  m_ct_valid,
   input  logic                  m_ct_ready,
   output logic                  cfg_done,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
   localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam logic [CntW:0] MaxCredit = (CntW + 1)'(MAX_INFLIGHT);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_INFLIGHT - 1);

   if (MAX_INFLIGHT < 2 || WDOG_CYCLES < 1) begin : g_param_check
      $error("feistel_encrypt_ctrl: MAX_INFLIGHT must be >= 2 and WDOG_CYCLES >= 1");
   end

   typedef enum logic [1:0] {StIdle, StSbox, StKey, StRun} state_e;

   state_e          state_q;
   logic [7:0]      byte_cnt_q;
   logic [1:0]      key_cnt_q;
   logic [CntW-1:0] eng_cnt_q;
   logic [CntW-1:0] fifo_cnt_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [DATA_WIDTH-1:0] fifo_mem [MAX_INFLIGHT];

   logic [CntW:0] credit;
   logic          sbox_acc;
   logic          pt_acc;
   logic          push;
   logic          pop;
   logic          wdog_err;

   assign credit   = {1'b0, eng_cnt_q} + {1'b0, fifo_cnt_q};
   assign sbox_acc = s_sbox_valid & s_sbox_ready;
   assign pt_acc   = s_pt_valid & s_pt_ready;
   // Returns with nothing outstanding are spurious and dropped entirely.
   assign push     = eng_valid & (eng_cnt_q != '0);
   assign pop      = m_ct_valid & m_ct_ready;

   assign s_sbox_ready = (state_q == StSbox);
   assign s_pt_ready   = (state_q == StRun) && (credit < MaxCredit) && !wdog_err;
   assign cfg_done     = (state_q == StRun);
   assign busy         = (credit != '0);
   assign m_ct_valid   = (fifo_cnt_q != '0);
   assign m_ct_data    = m_ct_valid ? fifo_mem[rd_ptr_q] : '0;
   assign err          = wdog_err;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         byte_cnt_q     <= '0;
         key_cnt_q      <= '0;
         eng_sbox_out   <= '0;
         eng_sbox_valid <= 1'b0;
         eng_key_valid  <= 1'b0;
      end else begin
         eng_sbox_valid <= sbox_acc;
         eng_key_valid  <= 1'b0;
         if (sbox_acc) begin
            eng_sbox_out <= s_sbox_data;
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StSbox;
                  byte_cnt_q <= '0;
               end
            end
            StSbox: begin
               if (sbox_acc) begin
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                  if (byte_cnt_q == 8'hFF) begin
                     state_q   <= StKey;
                     key_cnt_q <= '0;
                  end
               end
            end
            StKey: begin
               // First KEY cycle carries the last S-box byte; strobe the two after it.
               key_cnt_q     <= key_cnt_q + 2'd1;
               eng_key_valid <= (key_cnt_q != 2'd2);
               if (key_cnt_q == 2'd2) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (start && credit == '0) begin
                  state_q    <= StSbox;
                  byte_cnt_q <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eng_plaintext <= '0;
         eng_tvalid    <= 1'b0;
         eng_cnt_q     <= '0;
      end else begin
         eng_tvalid <= pt_acc;
         if (pt_acc) begin
            eng_plaintext <= s_pt_data;
         end
         case ({pt_acc, push})
            2'b10:   eng_cnt_q <= eng_cnt_q + CntW'(1);
            2'b01:   eng_cnt_q <= eng_cnt_q - CntW'(1);
            default: eng_cnt_q <= eng_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= eng_ciphertext;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

`ifdef FEISTEL_CTRL_WDOG_EN
   localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WdogW-1:0] WdogLimit = WdogW'(WDOG_CYCLES);

   logic [WdogW-1:0] wdog_cnt_q;
   logic             wdog_err_q;
   logic             stall;

   assign stall    = (eng_cnt_q != '0) && !eng_valid;
   assign wdog_err = wdog_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (!stall) begin
            wdog_cnt_q <= '0;
         end else if (wdog_cnt_q != WdogLimit) begin
            wdog_cnt_q <= wdog_cnt_q + WdogW'(1);
            if (wdog_cnt_q == WdogLimit - WdogW'(1)) begin
               wdog_err_q <= 1'b1;
            end
         end
      end
   end
`else
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_feistel_encrypt_ctrl.sv
// Scoreboard bench for feistel_encrypt_ctrl: directed config, credit, ordering, reset and watchdog scenarios.
module tb_feistel_encrypt_ctrl;
   localparam int SW  = 8;
   localparam int DW  = 256;
   localparam int MI  = 4;
   localparam int WDC = 16;
   localparam logic [DW-1:0] MASK = {8{32'hA5C3_0F96}};

   logic clk = 1'b0;
   logic reset_n, start;
   logic [SW-1:0] s_sbox_data;
   logic s_sbox_valid, s_sbox_ready;
   logic [SW-1:0] eng_sbox_out;
   logic eng_sbox_valid, eng_key_valid;
   logic [DW-1:0] s_pt_data, eng_plaintext, eng_ciphertext, m_ct_data;
   logic s_pt_valid, s_pt_ready, eng_tvalid, eng_valid;
   logic m_ct_valid, m_ct_ready, cfg_done, busy, err;

   feistel_encrypt_ctrl #(
      .SBOX_WIDTH(SW), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI), .WDOG_CYCLES(WDC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .s_sbox_data(s_sbox_data), .s_sbox_valid(s_sbox_valid), .s_sbox_ready(s_sbox_ready),
      .eng_sbox_out(eng_sbox_out), .eng_sbox_valid(eng_sbox_valid),
      .eng_key_valid(eng_key_valid),
      .s_pt_data(s_pt_data), .s_pt_valid(s_pt_valid), .s_pt_ready(s_pt_ready),
      .eng_plaintext(eng_plaintext), .eng_tvalid(eng_tvalid),
      .eng_ciphertext(eng_ciphertext), .eng_valid(eng_valid),
      .m_ct_data(m_ct_data), .m_ct_valid(m_ct_valid), .m_ct_ready(m_ct_ready),
      .cfg_done(cfg_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   logic [SW-1:0] exp_sbox[$];
   bit            exp_sv_bit[$];
   int            exp_sv_cyc[$];
   logic [DW-1:0] exp_ct[$];
   logic [DW-1:0] eng_q[$];
   int            eng_due[$];
   logic [DW-1:0] tx_q[$];
   int  eng_lat = 30;
   bit  eng_en = 1'b1;
   bit  spur = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pops and engine-issue capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (exp_sv_cyc.size() > 0 && exp_sv_cyc[0] == cyc) begin
            check("sbox_valid_pattern", eng_sbox_valid, exp_sv_bit.pop_front());
            void'(exp_sv_cyc.pop_front());
         end
         if (eng_sbox_valid) begin
            if (exp_sbox.size() == 0) check("sbox_extra", eng_sbox_valid, 1'b0);
            else check("sbox_data", eng_sbox_out, exp_sbox.pop_front());
         end
         if (m_ct_valid && m_ct_ready) begin
            if (exp_ct.size() == 0) check("ct_extra", m_ct_valid, 1'b0);
            else check("ct_data", m_ct_data, exp_ct.pop_front());
         end
         if (eng_tvalid) begin
            eng_q.push_back(eng_plaintext);
            eng_due.push_back(cyc + eng_lat);
         end
      end
   end

   // Engine model: fixed latency, ciphertext = plaintext ^ MASK.
   initial begin
      eng_valid = 1'b0;
      eng_ciphertext = '0;
      forever begin
         @(posedge clk);
         #1;
         eng_valid = spur;
         if (reset_n && eng_en && eng_q.size() > 0 && eng_due[0] <= cyc) begin
            eng_valid = 1'b1;
            eng_ciphertext = eng_q.pop_front() ^ MASK;
            void'(eng_due.pop_front());
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_s_sbox_ready"}, s_sbox_ready, 1'b0);
      check({tag, "_eng_sbox_valid"}, eng_sbox_valid, 1'b0);
      check({tag, "_eng_key_valid"}, eng_key_valid, 1'b0);
      check({tag, "_eng_tvalid"}, eng_tvalid, 1'b0);
      check({tag, "_s_pt_ready"}, s_pt_ready, 1'b0);
      check({tag, "_m_ct_valid"}, m_ct_valid, 1'b0);
      check({tag, "_cfg_done"}, cfg_done, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_eng_sbox_out"}, eng_sbox_out, '0);
      check({tag, "_eng_plaintext"}, eng_plaintext, '0);
      check({tag, "_m_ct_data"}, m_ct_data, '0);
   endtask

   task automatic do_config(input bit gaps);
      int n = 0;
      int i = 0;
      bit v;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("sbox_ready_in_sbox", s_sbox_ready, 1'b1);
      while (n < 256) begin
         v = gaps ? (i % 2 == 0) : 1'b1;
         s_sbox_valid = v;
         s_sbox_data = 8'(255 - n);
         exp_sv_bit.push_back(v);
         exp_sv_cyc.push_back(cyc + 1);
         if (v) begin
            exp_sbox.push_back(8'(255 - n));
            n++;
         end
         i++;
         tick();
      end
      s_sbox_valid = 1'b0;
      exp_sv_bit.push_back(1'b0); exp_sv_cyc.push_back(cyc + 1);
      exp_sv_bit.push_back(1'b0); exp_sv_cyc.push_back(cyc + 2);
      @(negedge clk);
      check("key_before", eng_key_valid, 1'b0);
      check("sbox_ready_in_key", s_sbox_ready, 1'b0);
      @(negedge clk);
      check("key_cycle1", eng_key_valid, 1'b1);
      check("cfg_done_in_key", cfg_done, 1'b0);
      @(negedge clk);
      check("key_cycle2", eng_key_valid, 1'b1);
      @(negedge clk);
      check("key_after", eng_key_valid, 1'b0);
      check("cfg_done_run", cfg_done, 1'b1);
      check("sbox_all_seen", exp_sbox.size(), 0);
      tick();
   endtask

   task automatic send_queue(input int budget, output int sent);
      sent = 0;
      while (tx_q.size() > 0 && budget > 0) begin
         s_pt_valid = 1'b1;
         s_pt_data = tx_q[0];
         if (s_pt_ready) begin
            exp_ct.push_back(tx_q[0] ^ MASK);
            void'(tx_q.pop_front());
            sent++;
         end
         tick();
         budget--;
      end
      s_pt_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      while ((busy || exp_ct.size() > 0) && budget > 0) begin
         tick();
         budget--;
      end
      check({tag, "_busy_clear"}, busy, 1'b0);
      check({tag, "_all_out"}, exp_ct.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish by 500000");
      $fatal(1);
   end

   initial begin
      int sent;
      int bound;
      reset_n = 1'b1; start = 1'b0; s_sbox_data = '0; s_sbox_valid = 1'b0;
      s_pt_data = '0; s_pt_valid = 1'b0; m_ct_ready = 1'b0;
      #2 reset_n = 1'b0;
      #2 check_all_zero("por");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      check("idle_no_cfg", cfg_done, 1'b0);
      check("idle_sbox_ready", s_sbox_ready, 1'b0);

      do_config(1'b0);
      do_config(1'b1);  // reconfiguration from RUN with zero credit, gapped input

      // Spurious engine return with nothing outstanding.
      spur = 1'b1;
      tick();
      spur = 1'b0;
      tick();
      check("spur_no_ct", m_ct_valid, 1'b0);
      check("spur_not_busy", busy, 1'b0);

      // Credit limit.
      eng_lat = 30;
      m_ct_ready = 1'b0;
      for (int k = 0; k < 6; k++) tx_q.push_back({8{32'hC0DE_0000 + 32'(k)}});
      send_queue(60, sent);
      check("credit_accepted", sent, 4);
      check("credit_ready_low", s_pt_ready, 1'b0);
      check("credit_busy", busy, 1'b1);
      check("credit_ct_valid", m_ct_valid, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("start_ignored_busy", cfg_done, 1'b1);
      m_ct_ready = 1'b1;
      s_pt_valid = 1'b1;
      s_pt_data = tx_q[0];
      check("ready_low_before_pop", s_pt_ready, 1'b0);
      send_queue(100, sent);
      check("credit_rest_sent", sent, 2);
      wait_drain("credit", 200);

      // Order, back-to-back issue, no-bypass on empty FIFO.
      eng_lat = 5;
      tx_q.push_back({2{128'h11223344556677889900AABBCCDDEEFF}});
      tx_q.push_back({2{128'hFFEEDDCCBBAA99887766554433226677}});
      tx_q.push_back({2{128'h11223344556677889900AABBCCDDEEFF}} ^ 256'h1);
      tx_q.push_back({2{128'hFFEEDDCCBBAA99887766554433226677}} ^ 256'h1);
      send_queue(20, sent);
      check("order_sent", sent, 4);
      bound = 40;
      @(negedge clk);
      while (!eng_valid && bound > 0) begin
         @(negedge clk);
         bound--;
      end
      check("order_first_return", eng_valid, 1'b1);
      check("no_bypass", m_ct_valid, 1'b0);
      @(negedge clk);
      check("valid_next_cycle", m_ct_valid, 1'b1);
      #6;
      wait_drain("order", 100);

      // Reset mid-RUN with two blocks in flight.
      eng_lat = 30;
      m_ct_ready = 1'b0;
      tx_q.push_back({8{32'h0BAD_F00D}});
      tx_q.push_back({8{32'h1234_5678}});
      send_queue(10, sent);
      tick(); tick(); tick();
      check("pre_reset_busy", busy, 1'b1);
      #3 reset_n = 1'b0;
      #1 check_all_zero("mid_run_reset");
      exp_ct.delete(); eng_q.delete(); eng_due.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      s_sbox_valid = 1'b1;
      tick(); tick();
      check("post_reset_idle_ready", s_sbox_ready, 1'b0);
      check("post_reset_no_cfg", cfg_done, 1'b0);
      check("post_reset_no_issue", eng_sbox_valid, 1'b0);
      s_sbox_valid = 1'b0;
      tick();
      do_config(1'b0);

      // Watchdog: engine never returns.
      eng_en = 1'b0;
      s_pt_valid = 1'b1;
      s_pt_data = {8{32'hDEAD_BEEF}};
      check("wdog_issue_ready", s_pt_ready, 1'b1);
      tick();
      s_pt_valid = 1'b0;
      repeat (8) tick();
      check("wdog_early_err", err, 1'b0);
`ifdef FEISTEL_CTRL_WDOG_EN
      bound = 40;
      while (!err && bound > 0) begin
         tick();
         bound--;
      end
      check("wdog_err_set", err, 1'b1);
      check("wdog_blocks_ready", s_pt_ready, 1'b0);
      repeat (5) tick();
      check("wdog_err_sticky", err, 1'b1);
`else
      repeat (40) tick();
      check("wdog_off_err", err, 1'b0);
      check("wdog_off_ready", s_pt_ready, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
